// File: rtl/mult_sequencer_if.sv
// Request/response bundle for the sequential multiplier.
// The master issues multiply requests and HI/LO writes; the slave returns status and HI/LO.
interface mult_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, is_signed, op_a, op_b, wr_hi, wr_lo, wr_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, is_signed, op_a, op_b, wr_hi, wr_lo, wr_data,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_sequencer.sv
// Sequential shift-and-add multiplier with HI/LO result registers (MULT/MULTU, MTHI/MTLO).
// Signed products are formed from operand magnitudes and negated once at the end.
// One multiply takes WIDTH RUN cycles plus one FINISH cycle.
module mult_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    mult_sequencer_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] COUNT_LOAD = CW'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FINISH
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [CW-1:0]      r_count;
    logic               r_neg;
    logic               r_done;

    logic               w_start_ok;
    logic               w_wr_ok;
    logic               w_run;
    logic               w_finish;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [2*WIDTH-1:0] w_product;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-state control strobes
    always_comb begin
        w_next     = r_state;
        w_start_ok = 1'b0;
        w_wr_ok    = 1'b0;
        w_run      = 1'b0;
        w_finish   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_wr_ok    = 1'b1;
                w_start_ok = bus.start;
                if (bus.start) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                w_run = 1'b1;
                if (r_count == CW'(1)) begin
                    w_next = S_FINISH;
                end
            end
            S_FINISH: begin
                w_finish = 1'b1;
                w_next   = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operand magnitudes and final sign correction; the most negative value maps to itself, which is its correct unsigned magnitude
    always_comb begin
        w_abs_a   = (bus.is_signed && bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
        w_abs_b   = (bus.is_signed && bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;
        w_product = r_neg ? -r_acc : r_acc;
    end

    // Datapath: operand capture, shift-and-add iterations, HI/LO update and direct writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_count  <= '0;
            r_neg    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_wr_ok && bus.wr_hi) begin
                r_hi <= bus.wr_data;
            end
            if (w_wr_ok && bus.wr_lo) begin
                r_lo <= bus.wr_data;
            end
            if (w_start_ok) begin
                r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
                r_mplier <= w_abs_b;
                r_neg    <= bus.is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
                r_acc    <= '0;
                r_count  <= COUNT_LOAD;
            end
            if (w_run) begin
                if (r_mplier[0]) begin
                    r_acc <= r_acc + r_mcand;
                end
                r_mplier <= r_mplier >> 1;
                r_mcand  <= r_mcand << 1;
                r_count  <= r_count - CW'(1);
            end
            if (w_finish) begin
                r_hi   <= w_product[2*WIDTH-1:WIDTH];
                r_lo   <= w_product[WIDTH-1:0];
                r_done <= 1'b1;
            end
        end
    end

    assign bus.busy = (r_state != S_IDLE);
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer: vector table plus multi-cycle corner sequences.
module tb_mult_sequencer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mult_sequencer_if #(.WIDTH(32)) bus ();

    mult_sequencer #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Present a request for one edge; returns just after the accepting edge
    task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        bus.start     = 1'b1;
        bus.is_signed = sgn;
        bus.op_a      = a;
        bus.op_b      = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Count edges until done, watching busy and HI/LO hold in between; bounded
    task automatic wait_done(input int n0, input logic [31:0] hh, input logic [31:0] hl,
                             output int n, output bit held_ok, output bit busy_ok);
        n       = n0;
        held_ok = 1'b1;
        busy_ok = 1'b1;
        while (n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.done) break;
            if (bus.hi !== hh || bus.lo !== hl) held_ok = 1'b0;
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    initial begin
        int n;
        bit hok;
        bit bok;
        logic [31:0] hh;
        logic [31:0] hl;

        vecs[0]  = '{1'b0, 32'd3,         32'd5,         32'h00000000, 32'h0000000F};
        vecs[1]  = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{1'b1, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000000, 32'h00000001};
        vecs[3]  = '{1'b1, 32'h80000000,  32'h80000000,  32'h40000000, 32'h00000000};
        vecs[4]  = '{1'b1, 32'hFFFFFFFE,  32'd3,         32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[5]  = '{1'b0, 32'd0,         32'h12345678,  32'h00000000, 32'h00000000};
        vecs[6]  = '{1'b1, 32'd7,         32'hFFFFFFFA,  32'hFFFFFFFF, 32'hFFFFFFD6};
        vecs[7]  = '{1'b0, 32'h00010000,  32'h00010000,  32'h00000001, 32'h00000000};
        vecs[8]  = '{1'b0, 32'h80000000,  32'd2,         32'h00000001, 32'h00000000};
        vecs[9]  = '{1'b1, 32'h80000000,  32'd1,         32'hFFFFFFFF, 32'h80000000};
        vecs[10] = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h00000000, 32'h80000000};
        vecs[11] = '{1'b0, 32'h0000FFFF,  32'h0000FFFF,  32'h00000000, 32'hFFFE0001};

        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.wr_hi     = 1'b0;
        bus.wr_lo     = 1'b0;
        bus.wr_data   = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset busy/done", 64'({bus.busy, bus.done}), 64'd0);
        check("reset hi/lo", {bus.hi, bus.lo}, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table-driven products
        for (int i = 0; i < 12; i++) begin
            launch(vecs[i].sgn, vecs[i].a, vecs[i].b);
            hh = bus.hi;
            hl = bus.lo;
            wait_done(0, hh, hl, n, hok, bok);
            check($sformatf("v%0d latency", i), 64'(n), 64'd33);
            check($sformatf("v%0d hold", i), 64'(hok), 64'd1);
            check($sformatf("v%0d busy", i), 64'({bok, bus.busy}), 64'b10);
            check($sformatf("v%0d product", i), {bus.hi, bus.lo}, {vecs[i].ehi, vecs[i].elo});
            @(posedge clk);
            #1;
            check($sformatf("v%0d done pulse", i), 64'(bus.done), 64'd0);
        end

        // Mid-RUN start and wr_hi are ignored
        launch(1'b0, 32'h100, 32'h100);
        hh = bus.hi;
        hl = bus.lo;
        repeat (5) @(posedge clk);
        #1;
        bus.start     = 1'b1;
        bus.is_signed = 1'b1;
        bus.op_a      = 32'd9;
        bus.op_b      = 32'd9;
        bus.wr_hi     = 1'b1;
        bus.wr_data   = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.wr_hi = 1'b0;
        wait_done(6, hh, hl, n, hok, bok);
        check("midrun latency", 64'(n), 64'd33);
        check("midrun hold", 64'(hok), 64'd1);
        check("midrun product", {bus.hi, bus.lo}, 64'h00000000_00010000);
        repeat (2) @(posedge clk);
        #1;
        check("midrun no requeue", 64'({bus.busy, bus.done}), 64'd0);

        // Reset mid-RUN discards the operation
        launch(1'b1, 32'hFFFFFFFD, 32'd5);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst busy/done", 64'({bus.busy, bus.done}), 64'd0);
        check("midrst hi/lo", {bus.hi, bus.lo}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("postrst idle", 64'({bus.busy, bus.done}), 64'd0);
        launch(1'b0, 32'd7, 32'd6);
        wait_done(0, 32'd0, 32'd0, n, hok, bok);
        check("postrst latency", 64'(n), 64'd33);
        check("postrst product", {bus.hi, bus.lo}, 64'd42);

        // Start held on the done cycle: accepted, second done 34 edges later
        check("b2b done cycle", 64'(bus.done), 64'd1);
        launch(1'b0, 32'd4, 32'd5);
        wait_done(1, 32'd0, 32'd42, n, hok, bok);
        check("b2b spacing", 64'(n), 64'd34);
        check("b2b product", {bus.hi, bus.lo}, 64'd20);
        @(posedge clk);
        #1;

        // Direct HI/LO writes in IDLE
        bus.wr_lo   = 1'b1;
        bus.wr_data = 32'h13579BDF;
        @(posedge clk);
        #1;
        bus.wr_lo = 1'b0;
        check("mtlo", {bus.hi, bus.lo}, 64'h00000000_13579BDF);
        bus.wr_hi   = 1'b1;
        bus.wr_lo   = 1'b1;
        bus.wr_data = 32'hA5A55A5A;
        @(posedge clk);
        #1;
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
        check("mthi+mtlo", {bus.hi, bus.lo}, 64'hA5A55A5A_A5A55A5A);

        // Write coincident with an accepted start lands, product later overwrites
        bus.wr_hi   = 1'b1;
        bus.wr_data = 32'h0BADF00D;
        launch(1'b0, 32'h10, 32'h10);
        bus.wr_hi = 1'b0;
        check("start+mthi", {bus.hi, bus.lo}, 64'h0BADF00D_A5A55A5A);
        wait_done(0, 32'h0BADF00D, 32'hA5A55A5A, n, hok, bok);
        check("start+mthi latency", 64'(n), 64'd33);
        check("start+mthi hold", 64'(hok), 64'd1);
        check("start+mthi product", {bus.hi, bus.lo}, 64'h00000000_00000100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
